// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: memory-port and requester handshake bundle for mem_arbiter.
// slave is the arbiter's view, master is the view of whoever drives the
// requests and models the RAM/IO pins.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_done;
   logic [31:0]           if_data;

   logic                  lsb_req;
   logic [3:0]            lsb_type;
   logic [ADDR_WIDTH-1:0] lsb_addr;
   logic [31:0]           lsb_wdata;
   logic                  lsb_done;
   logic [31:0]           lsb_rdata;

   modport slave (
      input  mem_din, if_req, if_addr, lsb_req, lsb_type, lsb_addr, lsb_wdata,
      output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata
   );

   modport master (
      output mem_din, if_req, if_addr, lsb_req, lsb_type, lsb_addr, lsb_wdata,
      input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between the instruction
// fetcher and the load/store buffer. Every access is split into byte
// transfers; load results are assembled little-endian and extended.
// Build option: define MEM_ARB_FAIR_EN for round-robin grant; when it is
// undefined the LSB always wins a tie and no pointer register exists.
module mem_arbiter #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h00030000)
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         flush,
   input  logic         io_buffer_full,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t                state, state_nxt;
   logic [2:0]            cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0] base, base_nxt;
   logic [3:0]            kind, kind_nxt;
   logic [31:0]           wdata, wdata_nxt;
   logic [31:0]           data_buf, data_buf_nxt;
   logic                  src_lsb, src_lsb_nxt;

   logic [ADDR_WIDTH-1:0] a_nxt;
   logic [7:0]            dout_nxt;
   logic                  wr_nxt;
   logic                  if_done_nxt, lsb_done_nxt;
   logic [31:0]           if_data_nxt, lsb_rdata_nxt;

   logic [2:0]            len, cnt_inc;
   logic [ADDR_WIDTH-1:0] addr_inc, grant_addr;
   logic [31:0]           merged;
   logic                  if_ok, lsb_ok, grant_lsb;

   function automatic logic [2:0] size_bytes(input logic [3:0] t);
      case (t[1:0])
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
      is_io = (a >= IO_BASE);
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
      case (k)
         2'd0:    byte_sel = w[7:0];
         2'd1:    byte_sel = w[15:8];
         2'd2:    byte_sel = w[23:16];
         default: byte_sel = w[31:24];
      endcase
   endfunction

   // pos is the byte counter, which runs one ahead of the byte on mem_din
   function automatic logic [31:0] merge_byte(input logic [31:0] b, input logic [7:0] d,
                                              input logic [2:0] pos);
      merge_byte = b;
      case (pos)
         3'd1:    merge_byte[7:0]   = d;
         3'd2:    merge_byte[15:8]  = d;
         3'd3:    merge_byte[23:16] = d;
         3'd4:    merge_byte[31:24] = d;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [3:0] t);
      case (t[1:0])
         2'b00:   extend = t[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   extend = t[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   assign len        = size_bytes(kind);
   assign cnt_inc    = cnt + 3'd1;
   assign addr_inc   = base + ADDR_WIDTH'(cnt_inc);
   assign merged     = merge_byte(data_buf, bus.mem_din, cnt);
   // a side whose done pulse is showing is still holding req; do not regrant it
   assign if_ok      = bus.if_req && !bus.if_done && !flush;
   assign lsb_ok     = bus.lsb_req && !bus.lsb_done && !(flush && bus.lsb_type[3]);
   assign grant_addr = grant_lsb ? bus.lsb_addr : bus.if_addr;

`ifdef MEM_ARB_FAIR_EN
   logic ptr_lsb, ptr_nxt;

   assign grant_lsb = lsb_ok && (!if_ok || ptr_lsb);
   assign ptr_nxt   = (state == IDLE && rdy_in && (if_ok || lsb_ok)) ? !grant_lsb : ptr_lsb;

   // round-robin pointer: names the side that wins the next tie
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) ptr_lsb <= 1'b1;
      else        ptr_lsb <= ptr_nxt;
   end
`else
   assign grant_lsb = lsb_ok;
`endif

   // next-state and next-output decode for the byte sequencer
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      base_nxt      = base;
      kind_nxt      = kind;
      wdata_nxt     = wdata;
      data_buf_nxt  = data_buf;
      src_lsb_nxt   = src_lsb;
      a_nxt         = bus.mem_a;
      dout_nxt      = bus.mem_dout;
      wr_nxt        = 1'b0;
      if_done_nxt   = 1'b0;
      lsb_done_nxt  = 1'b0;
      if_data_nxt   = bus.if_data;
      lsb_rdata_nxt = bus.lsb_rdata;
      if (!rdy_in) begin
         if_done_nxt  = bus.if_done;
         lsb_done_nxt = bus.lsb_done;
      end else begin
         case (state)
            IDLE: begin
               if (if_ok || lsb_ok) begin
                  src_lsb_nxt  = grant_lsb;
                  base_nxt     = grant_addr;
                  kind_nxt     = grant_lsb ? bus.lsb_type : 4'b1010;
                  wdata_nxt    = bus.lsb_wdata;
                  cnt_nxt      = 3'd0;
                  data_buf_nxt = 32'd0;
                  a_nxt        = grant_addr;
                  if (grant_lsb && !bus.lsb_type[3]) begin
                     state_nxt = WR;
                     dout_nxt  = bus.lsb_wdata[7:0];
                     wr_nxt    = !(is_io(bus.lsb_addr) && io_buffer_full);
                  end else begin
                     state_nxt = RD;
                  end
               end
            end
            RD: begin
               if (flush) begin
                  state_nxt = IDLE;
                  cnt_nxt   = 3'd0;
               end else begin
                  if (cnt != 3'd0) data_buf_nxt = merged;
                  if (cnt_inc < len) a_nxt = addr_inc;
                  if (cnt == len) begin
                     state_nxt = IDLE;
                     cnt_nxt   = 3'd0;
                     if (src_lsb) begin
                        lsb_done_nxt  = 1'b1;
                        lsb_rdata_nxt = extend(merged, kind);
                     end else begin
                        if_done_nxt = 1'b1;
                        if_data_nxt = merged;
                     end
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end
            end
            WR: begin
               // mem_wr high means the byte on the pins was taken this cycle
               if (bus.mem_wr) begin
                  if (cnt_inc == len) begin
                     state_nxt    = IDLE;
                     cnt_nxt      = 3'd0;
                     lsb_done_nxt = 1'b1;
                  end else begin
                     cnt_nxt  = cnt_inc;
                     a_nxt    = addr_inc;
                     dout_nxt = byte_sel(wdata, cnt_inc[1:0]);
                     wr_nxt   = !(is_io(addr_inc) && io_buffer_full);
                  end
               end else begin
                  wr_nxt = !(is_io(bus.mem_a) && io_buffer_full);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // state, transaction context and registered outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= IDLE;
         cnt           <= 3'd0;
         base          <= '0;
         kind          <= 4'd0;
         wdata         <= 32'd0;
         data_buf      <= 32'd0;
         src_lsb       <= 1'b0;
         bus.mem_a     <= '0;
         bus.mem_dout  <= 8'd0;
         bus.mem_wr    <= 1'b0;
         bus.if_done   <= 1'b0;
         bus.if_data   <= 32'd0;
         bus.lsb_done  <= 1'b0;
         bus.lsb_rdata <= 32'd0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         base          <= base_nxt;
         kind          <= kind_nxt;
         wdata         <= wdata_nxt;
         data_buf      <= data_buf_nxt;
         src_lsb       <= src_lsb_nxt;
         bus.mem_a     <= a_nxt;
         bus.mem_dout  <= dout_nxt;
         bus.mem_wr    <= wr_nxt;
         bus.if_done   <= if_done_nxt;
         bus.if_data   <= if_data_nxt;
         bus.lsb_done  <= lsb_done_nxt;
         bus.lsb_rdata <= lsb_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a one-cycle-latency
// byte RAM model and a log of every byte written on the port.
module tb_mem_arbiter;

   logic clk_in;
   logic rst_in;
   logic rdy_in;
   logic flush;
   logic io_buffer_full;

   mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

   mem_arbiter #(.ADDR_WIDTH(32)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .flush          (flush),
      .io_buffer_full (io_buffer_full),
      .bus            (bus)
   );

   logic [7:0]  ram [0:1023];
   logic [31:0] wlog_addr [$];
   logic [7:0]  wlog_data [$];

   int passed = 0;
   int total  = 0;
   int idx;

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // RAM answers one cycle after the address; writes are logged, not stored
   always @(posedge clk_in) begin
      bus.mem_din <= ram[bus.mem_a[9:0]];
      if (bus.mem_wr) begin
         wlog_addr.push_back(bus.mem_a);
         wlog_data.push_back(bus.mem_dout);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of run, required $finish before 200000ns");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h10; ram[10'h103] = 8'h00;
      ram[10'h020] = 8'h80;
      ram[10'h050] = 8'h34; ram[10'h051] = 8'hF2;
      ram[10'h200] = 8'hB7; ram[10'h201] = 8'h12; ram[10'h202] = 8'h34; ram[10'h203] = 8'h56;

      rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = 32'd0;
      bus.lsb_req = 1'b0; bus.lsb_type = 4'd0; bus.lsb_addr = 32'd0; bus.lsb_wdata = 32'd0;

      // reset values
      tick(); tick();
      chk("rst_mem_a", bus.mem_a, 32'd0);
      chk("rst_mem_wr", bus.mem_wr, 32'd0);
      chk("rst_mem_dout", bus.mem_dout, 32'd0);
      chk("rst_if_done", bus.if_done, 32'd0);
      chk("rst_if_data", bus.if_data, 32'd0);
      chk("rst_lsb_done", bus.lsb_done, 32'd0);
      chk("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
      rst_in = 1'b0;
      tick();

      // instruction fetch from 0x100
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("fetch_addr%0d", k), bus.mem_a, 32'h100 + k);
         chk($sformatf("fetch_wr%0d", k), bus.mem_wr, 32'd0);
      end
      tick();
      chk("fetch_done_early", bus.if_done, 32'd0);
      tick();
      chk("fetch_done", bus.if_done, 32'd1);
      chk("fetch_data", bus.if_data, 32'h00100513);
      bus.if_req = 1'b0;
      tick();
      chk("fetch_done_pulse", bus.if_done, 32'd0);

      // signed byte load
      bus.lsb_req = 1'b1; bus.lsb_type = 4'b1000; bus.lsb_addr = 32'h20;
      tick();
      chk("lb_addr", bus.mem_a, 32'h20);
      tick();
      chk("lb_done_early", bus.lsb_done, 32'd0);
      tick();
      chk("lb_done", bus.lsb_done, 32'd1);
      chk("lb_data", bus.lsb_rdata, 32'hFFFFFF80);
      bus.lsb_req = 1'b0;
      tick();

      // unsigned byte load
      bus.lsb_req = 1'b1; bus.lsb_type = 4'b1100; bus.lsb_addr = 32'h20;
      tick(); tick(); tick();
      chk("lbu_done", bus.lsb_done, 32'd1);
      chk("lbu_data", bus.lsb_rdata, 32'h00000080);
      bus.lsb_req = 1'b0;
      tick();

      // signed half load
      bus.lsb_req = 1'b1; bus.lsb_type = 4'b1001; bus.lsb_addr = 32'h50;
      tick(); tick();
      chk("lh_addr1", bus.mem_a, 32'h51);
      tick(); tick();
      chk("lh_done", bus.lsb_done, 32'd1);
      chk("lh_data", bus.lsb_rdata, 32'hFFFFF234);
      bus.lsb_req = 1'b0;
      tick();

      // half store, held off by rdy_in for two cycles first
      rdy_in = 1'b0;
      bus.lsb_req = 1'b1; bus.lsb_type = 4'b0001; bus.lsb_addr = 32'h40; bus.lsb_wdata = 32'hDEADBEEF;
      idx = wlog_addr.size();
      tick(); tick();
      chk("rdy_hold_wr", bus.mem_wr, 32'd0);
      chk("rdy_hold_a", bus.mem_a, 32'h51);
      rdy_in = 1'b1;
      tick();
      chk("sh_wr0", bus.mem_wr, 32'd1);
      chk("sh_a0", bus.mem_a, 32'h40);
      chk("sh_d0", bus.mem_dout, 32'hEF);
      tick();
      chk("sh_wr1", bus.mem_wr, 32'd1);
      chk("sh_a1", bus.mem_a, 32'h41);
      chk("sh_d1", bus.mem_dout, 32'hBE);
      chk("sh_done_early", bus.lsb_done, 32'd0);
      tick();
      chk("sh_done", bus.lsb_done, 32'd1);
      chk("sh_wr_end", bus.mem_wr, 32'd0);
      chk("sh_nwrites", wlog_addr.size() - idx, 32'd2);
      chk("sh_log_a1", wlog_addr[idx+1], 32'h41);
      chk("sh_log_d1", wlog_data[idx+1], 32'hBE);
      bus.lsb_req = 1'b0;
      tick();

      // IO word store: flush at grant, buffer full for three cycles, flush mid-store
      idx = wlog_addr.size();
      bus.lsb_req = 1'b1; bus.lsb_type = 4'b0010; bus.lsb_addr = 32'h30000; bus.lsb_wdata = 32'h11223344;
      io_buffer_full = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("io_grant_a", bus.mem_a, 32'h30000);
      chk("io_stall_wr1", bus.mem_wr, 32'd0);
      tick();
      chk("io_stall_wr2", bus.mem_wr, 32'd0);
      tick();
      io_buffer_full = 1'b0;
      chk("io_stall_wr3", bus.mem_wr, 32'd0);
      tick();
      flush = 1'b1;
      chk("io_wr0", bus.mem_wr, 32'd1);
      chk("io_d0", bus.mem_dout, 32'h44);
      chk("io_nostall_writes", wlog_addr.size() - idx, 32'd0);
      tick();
      flush = 1'b0;
      chk("io_a1", bus.mem_a, 32'h30001);
      chk("io_wr1", bus.mem_wr, 32'd1);
      tick(); tick(); tick();
      chk("io_done", bus.lsb_done, 32'd1);
      chk("io_nwrites", wlog_addr.size() - idx, 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("io_log_a%0d", k), wlog_addr[idx+k], 32'h30000 + k);
         chk($sformatf("io_log_d%0d", k), wlog_data[idx+k], 32'h44 - 32'h11 * k);
      end
      bus.lsb_req = 1'b0;
      tick();

      // flush aborts a fetch; the next fetch is granted right after
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      tick(); tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; bus.if_addr = 32'h200;
      chk("flush_no_done", bus.if_done, 32'd0);
      tick();
      chk("flush_regrant_a", bus.mem_a, 32'h200);
      chk("flush_regrant_done", bus.if_done, 32'd0);
      tick(); tick(); tick(); tick(); tick();
      chk("refetch_done", bus.if_done, 32'd1);
      chk("refetch_data", bus.if_data, 32'h563412B7);
      bus.if_req = 1'b0;
      tick();

      // asynchronous reset in the middle of a fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      tick(); tick();
      chk("arst_pre_a", bus.mem_a, 32'h101);
      rst_in = 1'b1;
      #1;
      chk("arst_a", bus.mem_a, 32'd0);
      bus.if_req = 1'b0;
      tick();
      rst_in = 1'b0;
      tick();

      // simultaneous requests twice in succession
      for (int r = 0; r < 2; r++) begin
         bus.if_req = 1'b1; bus.if_addr = 32'h100;
         bus.lsb_req = 1'b1; bus.lsb_type = 4'b1000; bus.lsb_addr = 32'h20;
         tick();
         chk($sformatf("arb%0d_first_lsb", r), bus.mem_a, 32'h20);
         tick(); tick();
         chk($sformatf("arb%0d_lsb_done", r), bus.lsb_done, 32'd1);
         bus.lsb_req = 1'b0;
         tick();
         chk($sformatf("arb%0d_then_if", r), bus.mem_a, 32'h100);
         tick(); tick(); tick(); tick(); tick();
         chk($sformatf("arb%0d_if_done", r), bus.if_done, 32'd1);
         bus.if_req = 1'b0;
         tick();
      end

      // lone LSB load, then a tie: round-robin picks IF, fixed priority picks LSB
      bus.lsb_req = 1'b1; bus.lsb_type = 4'b1000; bus.lsb_addr = 32'h20;
      tick(); tick(); tick();
      chk("tie_pre_done", bus.lsb_done, 32'd1);
      bus.lsb_req = 1'b0;
      tick();
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      bus.lsb_req = 1'b1;
      tick();
`ifdef MEM_ARB_FAIR_EN
      chk("tie_winner", bus.mem_a, 32'h100);
`else
      chk("tie_winner", bus.mem_a, 32'h20);
`endif
      bus.if_req = 1'b0; bus.lsb_req = 1'b0;
      for (int k = 0; k < 8; k++) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
